// File: rtl/dct_pingpong_ctrl.sv
// Sequencer for the 16x16 2-D DCT: accepts pixel rows, steers them into ping-pong
// transpose banks, drains each full bank through the column DCT and tags output rows.
module dct_pingpong_ctrl #(
  parameter int N       = 16,
  parameter int CNT_W   = 4,
  parameter int ROW_LAT = 2,
  parameter int COL_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             flag,
  output logic [1:0]       tp_wr_en,
  output logic [1:0]       tp_rd_en,
  output logic             col_flag,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_row,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DRAINING} bank_state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  bank_state_t w_state [2];

  logic               r_wr_bank;
  logic               r_rd_bank;
  logic               r_col_flag;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_land_cnt;
  logic [ROW_LAT-1:0] r_wd_vld;
  logic [ROW_LAT-1:0] r_wd_bank;
  logic [COL_LAT-1:0] r_od_vld;
  logic [CNT_W-1:0]   r_od_row [COL_LAT];

  logic w_xfer;
  logic w_land;
  logic w_land_bank;
  logic w_land_last;
  logic w_rd_go;
  logic w_rd_first;
  logic w_rd_last;

  assign in_ready    = (w_state[r_wr_bank] == S_EMPTY) || (w_state[r_wr_bank] == S_FILLING);
  assign w_xfer      = in_valid && in_ready;
  assign w_land      = r_wd_vld[ROW_LAT-1];
  assign w_land_bank = r_wd_bank[ROW_LAT-1];
  assign w_land_last = w_land && (r_land_cnt == LAST);
  // The bank under rd_bank is the only one that can drain; it starts as soon as it is FULL.
  assign w_rd_go     = (w_state[r_rd_bank] == S_FULL) || (w_state[r_rd_bank] == S_DRAINING);
  assign w_rd_first  = w_rd_go && (w_state[r_rd_bank] == S_FULL);
  assign w_rd_last   = w_rd_go && (r_rd_cnt == LAST);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_t r_bstate;
    bank_state_t w_bstate_next;

    always_comb begin
      w_bstate_next = r_bstate;
      case (r_bstate)
        S_EMPTY:    if (w_xfer && (r_wr_bank == 1'(gi))) w_bstate_next = S_FILLING;
        S_FILLING:  if (w_land_last && (w_land_bank == 1'(gi))) w_bstate_next = S_FULL;
        S_FULL:     if (w_rd_go && (r_rd_bank == 1'(gi)))
                      w_bstate_next = w_rd_last ? S_EMPTY : S_DRAINING;
        S_DRAINING: if (w_rd_last && (r_rd_bank == 1'(gi))) w_bstate_next = S_EMPTY;
        default:    w_bstate_next = S_EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_bstate <= S_EMPTY;
      else       r_bstate <= w_bstate_next;
    end

    assign w_state[gi]  = r_bstate;
    assign tp_wr_en[gi] = w_land && (w_land_bank == 1'(gi));
    assign tp_rd_en[gi] = w_rd_go && (r_rd_bank == 1'(gi));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (w_xfer) begin
      r_wr_cnt <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + CNT_W'(1);
      if (r_wr_cnt == LAST) r_wr_bank <= ~r_wr_bank;
    end
  end

  // The bank id rides along with each row so a late write cannot follow a toggled wr_bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd_vld   <= '0;
      r_wd_bank  <= '0;
      r_land_cnt <= '0;
    end else begin
      r_wd_vld[0]  <= w_xfer;
      r_wd_bank[0] <= r_wr_bank;
      for (int i = 1; i < ROW_LAT; i++) begin
        r_wd_vld[i]  <= r_wd_vld[i-1];
        r_wd_bank[i] <= r_wd_bank[i-1];
      end
      if (w_land) r_land_cnt <= (r_land_cnt == LAST) ? '0 : r_land_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_col_flag <= 1'b0;
    end else begin
      if (w_rd_go) begin
        r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CNT_W'(1);
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
      if (w_rd_first) r_col_flag <= ~r_col_flag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_od_vld <= '0;
      for (int i = 0; i < COL_LAT; i++) r_od_row[i] <= '0;
    end else begin
      r_od_vld[0] <= w_rd_go;
      r_od_row[0] <= r_rd_cnt;
      for (int i = 1; i < COL_LAT; i++) begin
        r_od_vld[i] <= r_od_vld[i-1];
        r_od_row[i] <= r_od_row[i-1];
      end
    end
  end

  assign flag      = ~r_wr_bank;
  assign col_flag  = r_col_flag;
  assign out_valid = r_od_vld[COL_LAT-1];
  assign out_row   = r_od_row[COL_LAT-1];
  assign out_last  = out_valid && (out_row == LAST);
  assign busy      = (w_state[0] != S_EMPTY) || (w_state[1] != S_EMPTY) ||
                     (|r_wd_vld) || (|r_od_vld);

endmodule
